// File: rtl/mire_sdram_writer.sv
// Avalon-MM write master that paints a grid test pattern ("mire") into the SDRAM framebuffer.
// Define MIRE_CONTINUOUS_EN to rewrite the frame forever after the first start.
module mire_sdram_writer #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          GRID_LOG2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [XW-1:0] X_MASK = XW'((1 << GRID_LOG2) - 1);
  localparam logic [YW-1:0] Y_MASK = YW'((1 << GRID_LOG2) - 1);
  localparam logic [31:0]   PIX_LINE = 32'h00FF_FFFF;
  localparam logic [31:0]   PIX_BG   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    be_q;
  logic          write_q;
  logic          busy_q;
  logic          done_q;
  logic          accept_s;
  logic          last_s;
  logic          grid_s;

  // Next pixel coordinates and the colour of that pixel, used when a word is accepted.
  always_comb begin
    x_d      = x_q + XW'(1);
    y_d      = y_q;
    accept_s = write_q & ~avm_waitrequest;
    last_s   = (x_q == X_LAST) && (y_q == Y_LAST);
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end else begin
      x_d = x_q + XW'(1);
    end
    grid_s = ((x_d & X_MASK) == '0) || ((y_d & Y_MASK) == '0);
  end

  // Frame sequencer; every Avalon output is a register so it holds steady during stalls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'h0000_0000;
      be_q    <= 4'h0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= WRITE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= PIX_LINE;
            be_q    <= 4'hF;
            write_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITE: begin
          if (accept_s) begin
            if (last_s) begin
              state_q <= DONE;
              write_q <= 1'b0;
              be_q    <= 4'h0;
              data_q  <= 32'h0000_0000;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              addr_q <= addr_q + 32'd4;
              data_q <= grid_s ? PIX_LINE : PIX_BG;
            end
          end else begin
            state_q <= WRITE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
`ifdef MIRE_CONTINUOUS_EN
          state_q <= WRITE;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= BASE_ADDR;
          data_q  <= PIX_LINE;
          be_q    <= 4'hF;
          write_q <= 1'b1;
          busy_q  <= 1'b1;
`else
          state_q <= IDLE;
          addr_q  <= BASE_ADDR;
`endif
        end
        default: begin
          state_q <= IDLE;
          write_q <= 1'b0;
          be_q    <= 4'h0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_mire_sdram_writer.sv
// Directed self-checking bench for mire_sdram_writer on a 32x4 frame with a 16-pixel grid.
module tb_mire_sdram_writer;

  localparam int HD   = 32;
  localparam int VD   = 4;
  localparam int NPIX = HD * VD;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] lfsr = 16'hACE1;
  logic [31:0] got [NPIX];
  int          acc;
  int          dn;

  always #5 sys_clk = ~sys_clk;

  mire_sdram_writer #(
    .HDISP(HD), .VDISP(VD), .BASE_ADDR(32'h0000_0000), .GRID_LOG2(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done)
  );

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int k);
    int x;
    int y;
    x = k % HD;
    y = k / HD;
    return ((x % 16) == 0 || (y % 16) == 0) ? 32'h00FF_FFFF : 32'h0000_0000;
  endfunction

  // One frame: start pulse, optional random stalls, optional re-start or reset at a given accept count.
  task automatic run(input bit rnd, input int start_at, input int rst_at,
                     output int n_acc, output int n_done);
    int          budget;
    bit          stalled;
    bit          pulsed;
    bit          aborted;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        w;
    budget = 0; stalled = 1'b0; pulsed = 1'b0; aborted = 1'b0;
    pa = 32'h0; pd = 32'h0;
    n_acc = 0; n_done = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (n_acc < NPIX && budget < 4000) begin
      if (done) n_done++;
      chk("write_high", 32'(avm_write), 32'h1);
      if (stalled) begin
        chk("stall_addr", avm_address, pa);
        chk("stall_data", avm_writedata, pd);
        chk("stall_be", 32'(avm_byteenable), 32'hF);
      end
      w = rnd ? lfsr[0] : 1'b0;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      avm_waitrequest = w;
      start = (start_at >= 0 && n_acc == start_at && !pulsed);
      if (start) pulsed = 1'b1;
      if (rst_at >= 0 && n_acc == rst_at) begin
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_write", 32'(avm_write), 32'h0);
        aborted = 1'b1;
        break;
      end
      if (!w) begin
        chk("addr", avm_address, 32'(n_acc * 4));
        chk("data", avm_writedata, pix(n_acc));
        got[n_acc] = avm_writedata;
        n_acc++;
      end
      stalled = w;
      pa = avm_address;
      pd = avm_writedata;
      cyc();
      budget++;
    end
    start = 1'b0;
    avm_waitrequest = 1'b0;
    if (!aborted) begin
      chk("budget", 32'(budget < 4000), 32'h1);
      if (done) n_done++;
      chk("done_pulse", 32'(done), 32'h1);
      chk("done_write", 32'(avm_write), 32'h0);
      chk("done_busy", 32'(busy), 32'h0);
      chk("done_be", 32'(avm_byteenable), 32'h0);
      repeat (4) begin
        cyc();
        if (done) n_done++;
        chk("idle_write", 32'(avm_write), 32'h0);
      end
    end
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_write", 32'(avm_write), 32'h0);
    chk("rst_addr", avm_address, 32'h0);
    sys_rst_n = 1'b1;
    repeat (20) cyc();
    chk("idle_write", 32'(avm_write), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_done", 32'(done), 32'h0);
    chk("idle_addr", avm_address, 32'h0);
    chk("idle_be", 32'(avm_byteenable), 32'h0);

`ifdef MIRE_CONTINUOUS_EN
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NPIX; k++) begin
        start = (f == 1 && k == 5);
        chk("cont_write", 32'(avm_write), 32'h1);
        chk("cont_addr", avm_address, 32'(k * 4));
        chk("cont_data", avm_writedata, pix(k));
        chk("cont_busy", 32'(busy), 32'h1);
        chk("cont_done_low", 32'(done), 32'h0);
        cyc();
      end
      start = 1'b0;
      chk("cont_done", 32'(done), 32'h1);
      chk("cont_done_busy", 32'(busy), 32'h0);
      chk("cont_done_write", 32'(avm_write), 32'h0);
      cyc();
    end
`else
    // Clean frame, no stalls
    run(1'b0, -1, -1, acc, dn);
    chk("frame_accepts", 32'(acc), 32'(NPIX));
    chk("frame_dones", 32'(dn), 32'h1);
    chk("pix_0_0", got[0], 32'h00FF_FFFF);
    chk("pix_1_1", got[33], 32'h0000_0000);
    chk("pix_16_1", got[48], 32'h00FF_FFFF);
    chk("pix_5_0", got[5], 32'h00FF_FFFF);
    chk("last_addr_seen", 32'(acc * 4 - 4), 32'h1FC);

    // Random stalls
    run(1'b1, -1, -1, acc, dn);
    chk("stall_accepts", 32'(acc), 32'(NPIX));
    chk("stall_dones", 32'(dn), 32'h1);

    // Restart request mid-frame must be ignored
    run(1'b0, 40, -1, acc, dn);
    chk("restart_accepts", 32'(acc), 32'(NPIX));
    chk("restart_dones", 32'(dn), 32'h1);

    // Reset mid-frame, then a fresh frame from BASE_ADDR
    run(1'b0, -1, 60, acc, dn);
    repeat (3) cyc();
    chk("inrst_write", 32'(avm_write), 32'h0);
    chk("inrst_busy", 32'(busy), 32'h0);
    chk("inrst_addr", avm_address, 32'h0);
    sys_rst_n = 1'b1;
    repeat (3) cyc();
    chk("postrst_write", 32'(avm_write), 32'h0);
    run(1'b1, -1, -1, acc, dn);
    chk("postrst_accepts", 32'(acc), 32'(NPIX));
    chk("postrst_dones", 32'(dn), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mire_sdram_writer.md
Name: mire_sdram_writer

Overview:
- Avalon-MM write master that fills the SDRAM framebuffer with a grid test pattern (the "mire").
- Sits upstream of the SDRAM-reading video stream and the vga stage, and drives the SDRAM Avalon port that is currently tied off in Top.
- Runs in the sys_clk domain (100 MHz).
- Writes one 32-bit word per pixel, row-major, so the downstream reader finds a known image.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0).
- GRID_LOG2, 4, grid pitch is 2**GRID_LOG2 pixels.

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to write a frame
- avm_address  out  32  Avalon byte address
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  pixel word {8'h00,R[7:0],G[7:0],B[7:0]}
- avm_byteenable  out  4  always 4'hF while writing, 4'h0 otherwise
- avm_waitrequest  in  1  Avalon slave stall
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Clocking and reset: one clock, sys_clk; asynchronous active-low reset sys_rst_n.
- Values held while sys_rst_n=0:
  - state=IDLE, x=0, y=0
  - avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, avm_byteenable=0
  - busy=0, done=0
- Asserting reset mid-frame drops avm_write asynchronously and discards the frame. After release, the block waits for a new start.
- State IDLE:
  - On start=1, go to WRITE at the next edge. x=0, y=0, busy=1.
  - avm_write rises on the cycle after start is sampled.
- State WRITE:
  - avm_write=1, avm_byteenable=4'hF.
  - avm_address = BASE_ADDR + 4*(y*HDISP + x), truncated to 32 bits. The address is maintained incrementally: +4 per accepted word, no multiplier.
  - avm_writedata = 32'h00FF_FFFF if x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else 32'h0000_0000.
- Avalon handshake:
  - A transfer is accepted on a rising edge where avm_write=1 and avm_waitrequest=0.
  - While avm_waitrequest=1, avm_address, avm_writedata and avm_byteenable hold stable.
  - On acceptance, advance: x+1. If x==HDISP-1, then x=0 and y+1.
  - Throughput is one pixel per cycle when waitrequest stays low.
- Frame end:
  - Acceptance at x=HDISP-1, y=VDISP-1 goes to DONE.
  - avm_write deasserts in the same edge; it is never asserted for a (HDISP*VDISP+1)th word.
- State DONE, lasting one cycle:
  - done=1, busy=0, avm_byteenable=0, then IDLE.
- Start handling:
  - start while in WRITE or DONE is ignored, never queued.
  - start in IDLE the cycle after DONE starts a new frame normally.
- Counter widths: x is $clog2(HDISP) bits, y is $clog2(VDISP) bits. Wrap happens only at the explicit bounds above.
- Total words per frame: exactly HDISP*VDISP. Total bytes: 4*HDISP*VDISP.

Optional Feature:
- Macro: MIRE_CONTINUOUS_EN.
- When defined:
  - DONE returns to WRITE instead of IDLE, with x=0, y=0 and the address back at BASE_ADDR.
  - The framebuffer is rewritten forever after the first start.
  - done still pulses for one cycle per frame. busy stays 1, except during the DONE cycle where it is 0.
  - start is ignored after the first frame begins.
- When undefined: single-frame-per-start behaviour as specified above.

Test Plan:
- Reset, start=0 held 20 cycles -> avm_write=0, busy=0, done=0, avm_address=BASE_ADDR, byteenable=0.
- HDISP=32, VDISP=4, waitrequest=0, one start pulse:
  - avm_write is high for exactly 128 consecutive cycles, starting one cycle after start; addresses run 0x000..0x1FC in steps of 4.
  - Data: (0,0)=0x00FFFFFF, (1,1)=0x00000000, (16,1)=0x00FFFFFF, (5,0)=0x00FFFFFF.
  - done pulses once, one cycle after the last accept.
- Same configuration with pseudo-random waitrequest (50%) -> 128 accepts, no duplicate or missing address, and address/data stable during every stall cycle.
- start pulsed again at accept #40 -> ignored; total accepts stay 128; a single done pulse.
- sys_rst_n pulled low at accept #60 -> avm_write=0 without waiting for a clock edge. After release and a new start, writes restart at BASE_ADDR and 128 more accepts follow.
- MIRE_CONTINUOUS_EN defined, waitrequest=0 -> done pulses every 129 cycles; the address sequence 0x000..0x1FC repeats; busy=0 only on done cycles.
